// File: rtl/dmem_shared_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding
// and the lane-offset helper used to slice the packed per-core ports.
package dmem_shared_responder_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ACCESS = 2'd1;
    localparam logic [STATE_W-1:0] RESP   = 2'd2;

    // Low bit of lane `idx` in a packed bus of `width`-bit lanes.
    function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/dmem_shared_responder_rr_arbiter.sv
// Combinational round-robin grant: first requesting core at or after
// rr_ptr, wrapping from core_count-1 back to 0.
module rr_arbiter #(
    parameter int unsigned core_count = 2,
    parameter int unsigned ptr_w      = 1
) (
    input  logic [core_count-1:0] req,
    input  logic [ptr_w-1:0]      rr_ptr,
    output logic [ptr_w-1:0]      grant,
    output logic                  grant_valid
);

    logic [ptr_w-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < core_count; k++) begin
            idx = ptr_w'((32'(rr_ptr) + k) % core_count);
            if (!grant_valid && req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_shared_responder.sv
// Shared data-memory responder: round-robin arbitration of per-core
// load/store requests onto one single-port array, with one-cycle acks.
module dmem_shared_responder
    import dmem_shared_responder_pkg::*;
#(
    parameter int unsigned mem_size   = 4096,
    parameter int unsigned mem_width  = 12,
    parameter int unsigned addr_width = 12,
    parameter int unsigned core_count = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [core_count-1:0]            req,
    input  logic [core_count-1:0]            we,
    input  logic [core_count*addr_width-1:0] addr,
    input  logic [core_count*mem_width-1:0]  wdata,
    output logic [core_count*mem_width-1:0]  rdata,
    output logic [core_count-1:0]            ack,
    output logic                             busy
);

    localparam int unsigned ptr_w = $clog2(core_count);
    localparam int unsigned idx_w = (mem_size > 1) ? $clog2(mem_size) : 1;

    logic [STATE_W-1:0]              state;
    logic [ptr_w-1:0]                rr_ptr;
    logic [ptr_w-1:0]                grant;
    logic                            grant_valid;
    logic [ptr_w-1:0]                grant_q;
    logic                            we_q;
    logic [addr_width-1:0]           addr_q;
    logic [mem_width-1:0]            wdata_q;
    logic [addr_width-1:0]           grant_addr;
    logic [mem_width-1:0]            grant_wdata;
    logic                            grant_we;
    logic [core_count*mem_width-1:0] rdata_r;
    logic [core_count-1:0]           ack_r;
    logic                            in_range;
    logic [idx_w-1:0]                port_idx;
    logic                            ram_we;
    logic [mem_width-1:0]            ram_q;
    logic [mem_width-1:0]            mem [mem_size];

    rr_arbiter #(
        .core_count (core_count),
        .ptr_w      (ptr_w)
    ) u_arb (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        grant_addr  = '0;
        grant_wdata = '0;
        grant_we    = 1'b0;
        for (int unsigned i = 0; i < core_count; i++) begin
            if (grant == ptr_w'(i)) begin
                grant_addr  = addr[lane_lo(i, addr_width) +: addr_width];
                grant_wdata = wdata[lane_lo(i, mem_width) +: mem_width];
                grant_we    = we[i];
            end
        end
    end

    assign in_range = (32'(addr_q) < 32'(mem_size));

    // The array is read at the grant edge using the requester's address, so the
    // word is already in ram_q when ACCESS commits it to rdata; the single port
    // is shared with the ACCESS-cycle write via this address mux.
    assign port_idx = (state == IDLE) ? grant_addr[idx_w-1:0] : addr_q[idx_w-1:0];
    assign ram_we   = (state == ACCESS) && we_q && in_range && reset;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[port_idx] <= wdata_q;
        end
        ram_q <= mem[port_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_r <= '0;
            ack_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        grant_q <= grant;
                        we_q    <= grant_we;
                        addr_q  <= grant_addr;
                        wdata_q <= grant_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    for (int unsigned i = 0; i < core_count; i++) begin
                        if (grant_q == ptr_w'(i)) begin
                            ack_r[i] <= 1'b1;
                            if (!we_q) begin
                                rdata_r[lane_lo(i, mem_width) +: mem_width] <= in_range ? ram_q : '0;
                            end
                        end
                    end
                    state <= RESP;
                end
                RESP: begin
                    ack_r  <= '0;
                    rr_ptr <= (grant_q == ptr_w'(core_count - 1)) ? '0 : grant_q + ptr_w'(1);
                    state  <= IDLE;
                end
                default: begin
                    ack_r <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rdata = rdata_r;
    assign ack   = ack_r;
    assign busy  = (state != IDLE);

endmodule
